// File: rtl/pipe_alu_fwd.sv
// Four-stage ALU pipeline (read, execute, writeback, store) with distance-1/2 operand forwarding.
// Result on zout two edges after acceptance, memory store on the third; no stall, no backpressure.
module pipe_alu_fwd #(
  parameter int WIDTH = 16,
  parameter int RAW   = 4,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [RAW-1:0]   rs1,
  input  logic [RAW-1:0]   rs2,
  input  logic [RAW-1:0]   rd,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] imm,
  input  logic [AW-1:0]    addr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] zout,
  output logic             zout_valid,
  output logic             zout_zero,
  output logic             zout_carry,
  output logic             err
);

  localparam int NREG = 2**RAW;
  localparam int NMEM = 2**AW;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_mem  [NMEM];

  logic             r_s1_vld;
  logic [RAW-1:0]   r_s1_rs1, r_s1_rs2, r_s1_rd;
  logic [3:0]       r_s1_func;
  logic [WIDTH-1:0] r_s1_imm, r_s1_a, r_s1_b;
  logic [AW-1:0]    r_s1_addr;

  logic             r_s2_vld, r_s2_ill, r_s2_cy;
  logic [RAW-1:0]   r_s2_rd;
  logic [WIDTH-1:0] r_s2_res;
  logic [AW-1:0]    r_s2_addr;

  logic             r_s3_vld;
  logic [WIDTH-1:0] r_s3_res;
  logic [AW-1:0]    r_s3_addr;

  logic             w_wr_en;
  logic [WIDTH-1:0] w_rd_a, w_rd_b, w_a, w_b, w_res;
  logic             w_cy, w_ill, w_lt;

  // The S2 result is both the register written this edge (bypass into S1)
  // and the immediately preceding instruction's result (forward into execute).
  assign w_wr_en = r_s2_vld & ~r_s2_ill;
  assign w_rd_a  = (w_wr_en && r_s2_rd == rs1) ? r_s2_res : r_regs[rs1];
  assign w_rd_b  = (w_wr_en && r_s2_rd == rs2) ? r_s2_res : r_regs[rs2];
  assign w_a     = (w_wr_en && r_s2_rd == r_s1_rs1) ? r_s2_res : r_s1_a;
  assign w_b     = (w_wr_en && r_s2_rd == r_s1_rs2) ? r_s2_res : r_s1_b;
  assign w_lt    = $signed(w_a) < $signed(w_b);

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    w_ill = 1'b0;
    case (r_s1_func)
      4'd0:  {w_cy, w_res} = {1'b0, w_a} + {1'b0, w_b};
      4'd1:  {w_cy, w_res} = {1'b0, w_b} - {1'b0, w_a};
      4'd2:  w_res = w_a * w_b;
      4'd3:  w_res = w_a;
      4'd4:  w_res = w_b;
      4'd5:  w_res = w_a & w_b;
      4'd6:  w_res = w_a | w_b;
      4'd7:  w_res = w_a ^ w_b;
      4'd8:  w_res = '0 - w_a;
      4'd9:  w_res = '0 - w_b;
      4'd10: w_res = {1'b0, w_a[WIDTH-1:1]};
      4'd11: w_res = {w_a[WIDTH-2:0], 1'b0};
      4'd12: w_res = {w_a[WIDTH-1], w_a[WIDTH-1:1]};
      4'd13: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      4'd15: w_res = r_s1_imm;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_rd    <= '0;
      r_s1_func  <= '0;
      r_s1_imm   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_addr  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_ill   <= 1'b0;
      r_s2_cy    <= 1'b0;
      r_s2_rd    <= '0;
      r_s2_res   <= '0;
      r_s2_addr  <= '0;
      r_s3_vld   <= 1'b0;
      r_s3_res   <= '0;
      r_s3_addr  <= '0;
      zout       <= '0;
      zout_valid <= 1'b0;
      zout_zero  <= 1'b0;
      zout_carry <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_s1_vld  <= in_valid;
      r_s1_rs1  <= rs1;
      r_s1_rs2  <= rs2;
      r_s1_rd   <= rd;
      r_s1_func <= func;
      r_s1_imm  <= imm;
      r_s1_a    <= w_rd_a;
      r_s1_b    <= w_rd_b;
      r_s1_addr <= addr;

      r_s2_vld  <= r_s1_vld;
      r_s2_ill  <= w_ill;
      r_s2_cy   <= w_cy;
      r_s2_rd   <= r_s1_rd;
      r_s2_res  <= w_res;
      r_s2_addr <= r_s1_addr;

      if (w_wr_en) r_regs[r_s2_rd] <= r_s2_res;
      zout       <= r_s2_vld ? r_s2_res : '0;
      zout_valid <= r_s2_vld;
      zout_zero  <= w_wr_en & (r_s2_res == '0);
      zout_carry <= r_s2_vld & r_s2_cy;
      err        <= r_s2_vld & r_s2_ill;

      r_s3_vld  <= w_wr_en;
      r_s3_res  <= r_s2_res;
      r_s3_addr <= r_s2_addr;
    end
  end

  // Data memory keeps its contents across reset; r_s3_vld clears asynchronously,
  // so nothing in flight can store once rst_n falls.
  always_ff @(posedge clk) begin
    if (r_s3_vld) r_mem[r_s3_addr] <= r_s3_res;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Directed-vector bench for pipe_alu_fwd: stimulus pushes expected writeback results into a
// queue, an independent negedge monitor pops and compares them whenever zout_valid is seen.
module tb_pipe_alu_fwd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
  logic [15:0] imm = '0;
  logic [7:0]  addr = '0, rd_addr = '0;
  logic [15:0] rd_data, zout;
  logic        zout_valid, zout_zero, zout_carry, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       nm;
    logic [15:0] z;
    logic        zf, cf, er;
    int          at;
  } exp_t;
  exp_t q[$];

  pipe_alu_fwd #(.WIDTH(16), .RAW(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .imm(imm), .addr(addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .zout(zout), .zout_valid(zout_valid), .zout_zero(zout_zero),
    .zout_carry(zout_carry), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (zout_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got zout=%h with no instruction pending", zout);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.nm, "_result"}, {13'd0, zout_zero, zout_carry, err, zout},
              {13'd0, e.zf, e.cf, e.er, e.z});
        check({e.nm, "_latency"}, cyc, e.at);
      end
    end
  end

  // Called at posedge+1; the instruction is captured by the next rising edge.
  task automatic issue(input string nm, input logic [3:0] f, input logic [3:0] d,
                       input logic [3:0] a1, input logic [3:0] a2, input logic [15:0] im,
                       input logic [7:0] ad, input logic [15:0] ez, input logic ec,
                       input logic ee);
    exp_t e;
    in_valid = 1'b1;
    func = f; rd = d; rs1 = a1; rs2 = a2; imm = im; addr = ad;
    e.nm = nm; e.z = ez; e.cf = ec; e.er = ee;
    e.zf = (ez == 16'h0000) && !ee;
    e.at = cyc + 3;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Bubble carries a live-looking payload that must never reach the bank or memory.
  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      func = 4'd15; rd = 4'd1; rs1 = 4'd1; rs2 = 4'd2; imm = 16'hDEAD; addr = 8'h30;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mem_check(input string nm, input logic [7:0] a, input logic [15:0] v);
    rd_addr = a;
    #1;
    check(nm, {16'd0, rd_data}, {16'd0, v});
  endtask

  task automatic out_zero_check(input string nm);
    check({nm, "_zout"}, {16'd0, zout}, 32'd0);
    check({nm, "_flags"}, {28'd0, zout_valid, zout_zero, zout_carry, err}, 32'd0);
  endtask

  initial begin
    #1;
    out_zero_check("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Immediate write, result two edges later, store on the third.
    issue("imm5", 4'd15, 4'd1, 4'd0, 4'd0, 16'h0005, 8'h10, 16'h0005, 1'b0, 1'b0);
    bubble(3);
    mem_check("mem_imm5", 8'h10, 16'h0005);

    // Back-to-back: rs1 at distance 2, rs2 at distance 1, then chained distance 1.
    issue("ld_r1", 4'd15, 4'd1, 4'd0, 4'd0, 16'h0005, 8'h11, 16'h0005, 1'b0, 1'b0);
    issue("ld_r2", 4'd15, 4'd2, 4'd0, 4'd0, 16'h0003, 8'h12, 16'h0003, 1'b0, 1'b0);
    issue("add_fwd", 4'd0, 4'd4, 4'd1, 4'd2, 16'h0000, 8'h13, 16'h0008, 1'b0, 1'b0);
    issue("sub_fwd", 4'd1, 4'd5, 4'd2, 4'd4, 16'h0000, 8'h14, 16'h0005, 1'b0, 1'b0);

    issue("ld_r3", 4'd15, 4'd3, 4'd0, 4'd0, 16'h0007, 8'h15, 16'h0007, 1'b0, 1'b0);
    bubble(1);
    issue("byp_d2", 4'd3, 4'd6, 4'd3, 4'd0, 16'h0000, 8'h16, 16'h0007, 1'b0, 1'b0);
    issue("ld_r7", 4'd15, 4'd7, 4'd0, 4'd0, 16'h0009, 8'h17, 16'h0009, 1'b0, 1'b0);
    bubble(2);
    issue("bank_d3", 4'd4, 4'd8, 4'd0, 4'd7, 16'h0000, 8'h18, 16'h0009, 1'b0, 1'b0);

    // Full operation sweep with A=0xFFFF, B=0x0001.
    issue("ld_ffff", 4'd15, 4'd1, 4'd0, 4'd0, 16'hFFFF, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("ld_0001", 4'd15, 4'd2, 4'd0, 4'd0, 16'h0001, 8'h40, 16'h0001, 1'b0, 1'b0);
    issue("add_wrap", 4'd0,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0000, 1'b1, 1'b0);
    issue("slt_neg",  4'd13, 4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0001, 1'b0, 1'b0);
    issue("sub_brw",  4'd1,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0002, 1'b1, 1'b0);
    issue("mul",      4'd2,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("pass_a",   4'd3,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("pass_b",   4'd4,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0001, 1'b0, 1'b0);
    issue("and",      4'd5,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0001, 1'b0, 1'b0);
    issue("or",       4'd6,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("xor",      4'd7,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFE, 1'b0, 1'b0);
    issue("neg_a",    4'd8,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h0001, 1'b0, 1'b0);
    issue("neg_b",    4'd9,  4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("srl",      4'd10, 4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'h7FFF, 1'b0, 1'b0);
    issue("sll",      4'd11, 4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFE, 1'b0, 1'b0);
    issue("sra",      4'd12, 4'd10, 4'd1, 4'd2, 16'h0, 8'h40, 16'hFFFF, 1'b0, 1'b0);
    issue("sub_nobrw", 4'd1, 4'd10, 4'd2, 4'd1, 16'h0, 8'h40, 16'hFFFE, 1'b0, 1'b0);
    issue("slt_false", 4'd13, 4'd10, 4'd2, 4'd1, 16'h0, 8'h40, 16'h0000, 1'b0, 1'b0);

    // Both operands hazard on the same rd.
    issue("ld_r9",   4'd15, 4'd9, 4'd0, 4'd0, 16'h0006, 8'h41, 16'h0006, 1'b0, 1'b0);
    issue("dbl_fwd", 4'd0,  4'd9, 4'd9, 4'd9, 16'h0000, 8'h41, 16'h000C, 1'b0, 1'b0);
    issue("dbl_fwd2", 4'd0, 4'd9, 4'd9, 4'd9, 16'h0000, 8'h41, 16'h0018, 1'b0, 1'b0);

    // Illegal op must neither write r2 nor store over mem[0x22].
    issue("ld_beef", 4'd15, 4'd12, 4'd0, 4'd0, 16'hBEEF, 8'h22, 16'hBEEF, 1'b0, 1'b0);
    issue("ld_1234", 4'd15, 4'd2,  4'd0, 4'd0, 16'h1234, 8'h40, 16'h1234, 1'b0, 1'b0);
    bubble(3);
    issue("illegal", 4'd14, 4'd2,  4'd2, 4'd2, 16'h5555, 8'h22, 16'h0000, 1'b0, 1'b1);
    issue("ill_d1",  4'd3,  4'd11, 4'd2, 4'd0, 16'h0000, 8'h23, 16'h1234, 1'b0, 1'b0);
    issue("ill_d2",  4'd4,  4'd11, 4'd0, 4'd2, 16'h0000, 8'h23, 16'h1234, 1'b0, 1'b0);
    issue("ill_d3",  4'd3,  4'd11, 4'd2, 4'd0, 16'h0000, 8'h23, 16'h1234, 1'b0, 1'b0);
    bubble(4);
    mem_check("mem_illegal", 8'h22, 16'hBEEF);

    // Reset with three instructions in flight.
    issue("ld_aaaa", 4'd15, 4'd1, 4'd0, 4'd0, 16'hAAAA, 8'h30, 16'hAAAA, 1'b0, 1'b0);
    bubble(3);
    mem_check("mem_pre_rst", 8'h30, 16'hAAAA);
    issue("fl_1", 4'd15, 4'd1, 4'd0, 4'd0, 16'h1111, 8'h30, 16'h1111, 1'b0, 1'b0);
    issue("fl_2", 4'd15, 4'd2, 4'd0, 4'd0, 16'h2222, 8'h30, 16'h2222, 1'b0, 1'b0);
    issue("fl_3", 4'd15, 4'd3, 4'd0, 4'd0, 16'h3333, 8'h30, 16'h3333, 1'b0, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    out_zero_check("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue("r1_clr", 4'd3, 4'd5, 4'd1, 4'd0, 16'h0000, 8'h31, 16'h0000, 1'b0, 1'b0);
    issue("r2_clr", 4'd4, 4'd5, 4'd0, 4'd2, 16'h0000, 8'h31, 16'h0000, 1'b0, 1'b0);
    issue("r12_clr", 4'd3, 4'd5, 4'd12, 4'd0, 16'h0000, 8'h31, 16'h0000, 1'b0, 1'b0);
    bubble(4);
    mem_check("mem_post_rst", 8'h30, 16'hAAAA);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    check("pending_results", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
